// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: picks the result source, waits for load data, then drives the register-file write port for one cycle.
// Define WB_FORWARD_EN to add the fwd_* bypass outputs that mirror the write port.
module lc3_writeback #(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic [REG_ADDR_W-1:0] wb_dest_i,
  input  logic [1:0]            wb_src_sel_i,
  input  logic                  wb_set_cc_i,
  input  logic [DATA_W-1:0]     alu_result_i,
  input  logic [DATA_W-1:0]     pc_plus1_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic [REG_ADDR_W-1:0] write_reg_o,
  output logic [DATA_W-1:0]     write_data_o,
  output logic                  reg_write_o,
  output logic                  cc_n_o,
  output logic                  cc_z_o,
  output logic                  cc_p_o,
  output logic                  wb_timeout_o
`ifdef WB_FORWARD_EN
  ,
  output logic                  fwd_valid_o,
  output logic [REG_ADDR_W-1:0] fwd_reg_o,
  output logic [DATA_W-1:0]     fwd_data_o
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MEM    = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_PC   = 2'b10;

  logic [1:0]            state_q, state_d;
  logic [REG_ADDR_W-1:0] dest_q,  dest_d;
  logic [DATA_W-1:0]     data_q,  data_d;
  logic                  setcc_q, setcc_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [2:0]            cc_q,    cc_d;
  logic                  to_q,    to_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic             expired;
  logic [2:0]       nzp;

  assign accept  = wb_valid_i && (state_q == S_IDLE);
  assign cnt_inc = cnt_q + CNT_W'(1);
  // MEM_TIMEOUT==0 disables the abort entirely; the counter just wraps harmlessly.
  assign expired = (MEM_TIMEOUT != 0) && (cnt_inc == CNT_W'(MEM_TIMEOUT));
  assign nzp     = {data_q[DATA_W-1], data_q == '0, !data_q[DATA_W-1] && (data_q != '0)};

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    data_d  = data_q;
    setcc_d = setcc_q;
    cnt_d   = cnt_q;
    cc_d    = cc_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (wb_src_sel_i)
            SEL_ALU, SEL_PC: begin
              dest_d  = wb_dest_i;
              setcc_d = wb_set_cc_i;
              data_d  = (wb_src_sel_i == SEL_PC) ? pc_plus1_i : alu_result_i;
              state_d = S_COMMIT;
            end
            SEL_MEM: begin
              dest_d  = wb_dest_i;
              setcc_d = wb_set_cc_i;
              cnt_d   = '0;
              state_d = S_MEM;
            end
            default: ;  // no-write op: consumed without side effects
          endcase
        end
      end
      S_MEM: begin
        // Load data on the expiry cycle still commits.
        if (mem_rvalid_i) begin
          data_d  = mem_rdata_i;
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_inc;
          if (expired) begin
            state_d = S_IDLE;
            to_d    = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (setcc_q) cc_d = nzp;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      dest_q  <= '0;
      data_q  <= '0;
      setcc_q <= 1'b0;
      cnt_q   <= '0;
      cc_q    <= 3'b010;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      setcc_q <= setcc_d;
      cnt_q   <= cnt_d;
      cc_q    <= cc_d;
      to_q    <= to_d;
    end
  end

  assign wb_ready_o   = (state_q == S_IDLE);
  assign reg_write_o  = (state_q == S_COMMIT);
  assign write_reg_o  = dest_q;
  assign write_data_o = data_q;
  assign cc_n_o       = cc_q[2];
  assign cc_z_o       = cc_q[1];
  assign cc_p_o       = cc_q[0];
  assign wb_timeout_o = to_q;

`ifdef WB_FORWARD_EN
  assign fwd_valid_o = reg_write_o;
  assign fwd_reg_o   = write_reg_o;
  assign fwd_data_o  = write_data_o;
`endif

endmodule

// File: tb/tb_lc3_writeback.sv
// Directed bench for lc3_writeback: a cycle timeline of expected outputs is built alongside the stimulus
// and compared against the DUT on every falling edge.
module tb_lc3_writeback;
  logic        clk = 1'b0;
  logic        reset, wb_valid, wb_ready, wb_set_cc, mem_rvalid, reg_write;
  logic [2:0]  wb_dest, write_reg;
  logic [1:0]  wb_src_sel;
  logic [15:0] alu_result, pc_plus1, mem_rdata, write_data;
  logic        cc_n, cc_z, cc_p, wb_timeout;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [2:0]  fwd_reg;
  logic [15:0] fwd_data;
`endif

  lc3_writeback #(.DATA_W(16), .REG_ADDR_W(3), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk), .reset_i(reset), .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
    .wb_dest_i(wb_dest), .wb_src_sel_i(wb_src_sel), .wb_set_cc_i(wb_set_cc),
    .alu_result_i(alu_result), .pc_plus1_i(pc_plus1), .mem_rdata_i(mem_rdata),
    .mem_rvalid_i(mem_rvalid), .write_reg_o(write_reg), .write_data_o(write_data),
    .reg_write_o(reg_write), .cc_n_o(cc_n), .cc_z_o(cc_z), .cc_p_o(cc_p),
    .wb_timeout_o(wb_timeout)
`ifdef WB_FORWARD_EN
    , .fwd_valid_o(fwd_valid), .fwd_reg_o(fwd_reg), .fwd_data_o(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        exp_we, exp_wchk, exp_rdy, exp_to;
  logic [2:0]  exp_reg, exp_cc;
  logic [15:0] exp_data;
  int n_chk = 0, n_pass = 0;

  function automatic logic [2:0] nzp(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("reg_write", 32'(reg_write), 32'(exp_we));
      if (exp_we || exp_wchk) begin
        chk("write_reg", 32'(write_reg), 32'(exp_reg));
        chk("write_data", 32'(write_data), 32'(exp_data));
      end
      chk("cc_nzp", 32'({cc_n, cc_z, cc_p}), 32'(exp_cc));
      chk("wb_ready", 32'(wb_ready), 32'(exp_rdy));
      chk("wb_timeout", 32'(wb_timeout), 32'(exp_to));
`ifdef WB_FORWARD_EN
      chk("fwd_valid", 32'(fwd_valid), 32'(exp_we));
      if (exp_we) begin
        chk("fwd_reg", 32'(fwd_reg), 32'(exp_reg));
        chk("fwd_data", 32'(fwd_data), 32'(exp_data));
      end
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    wb_valid   = 1'b0;
    mem_rvalid = 1'b0;
    exp_we     = 1'b0;
    exp_rdy    = 1'b1;
  endtask

  // sel 00/10: accept now, write next cycle, NZP (cc_after) the cycle after.
  task automatic reg_op(input logic [1:0] sel, input logic [2:0] dest, input logic [15:0] val,
                        input logic setcc, input logic [2:0] cc_after);
    wb_valid = 1'b1; wb_src_sel = sel; wb_dest = dest; wb_set_cc = setcc;
    alu_result = (sel == 2'b00) ? val : ~val;
    pc_plus1   = (sel == 2'b10) ? val : ~val;
    exp_we = 1'b0; exp_rdy = 1'b1;
    cyc();
    wb_valid = 1'b0; alu_result = 16'hdead; pc_plus1 = 16'hbeef;
    exp_we = 1'b1; exp_reg = dest; exp_data = val; exp_rdy = 1'b0;
    cyc();
    go_idle();
    exp_cc = cc_after;
  endtask

  // Load: rvalid arrives in the wait_n-th MEM_WAIT cycle.
  task automatic mem_op(input logic [2:0] dest, input logic [15:0] val, input int wait_n,
                        input logic setcc, input logic [2:0] cc_after);
    wb_valid = 1'b1; wb_src_sel = 2'b01; wb_dest = dest; wb_set_cc = setcc;
    alu_result = ~val;
    exp_we = 1'b0; exp_rdy = 1'b1;
    for (int i = 1; i <= wait_n; i++) begin
      cyc();
      wb_valid   = 1'b0;
      mem_rvalid = (i == wait_n);
      mem_rdata  = (i == wait_n) ? val : ~val;
      exp_rdy    = 1'b0;
    end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 16'h5a5a;
    exp_we = 1'b1; exp_reg = dest; exp_data = val; exp_rdy = 1'b0;
    cyc();
    go_idle();
    exp_cc = cc_after;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_src_sel = 2'b00; wb_dest = 3'd0; wb_set_cc = 1'b0;
    alu_result = 16'd0; pc_plus1 = 16'd0; mem_rdata = 16'd0; mem_rvalid = 1'b0;
    exp_we = 1'b0; exp_wchk = 1'b1; exp_reg = 3'd0; exp_data = 16'd0;
    exp_cc = 3'b010; exp_rdy = 1'b1; exp_to = 1'b0;

    // Reset held 3 cycles; outputs checked from the first post-edge cycle.
    cyc(); chk_en = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    exp_wchk = 1'b0;

    // ALU 0x8001 -> R3, negative.
    reg_op(2'b00, 3'd3, 16'h8001, 1'b1, 3'b100);
    // Back-to-back ALU with set_cc=0: NZP must stay 100.
    reg_op(2'b00, 3'd1, 16'h0000, 1'b0, 3'b100);
    // Load zero into R5 after 4 wait cycles.
    mem_op(3'd5, 16'h0000, 4, 1'b1, 3'b010);
    // rvalid on the expiry cycle still commits.
    mem_op(3'd2, 16'h7fff, 15, 1'b1, nzp(16'h7fff));
    // rvalid while idle is ignored.
    mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    cyc();
    mem_rvalid = 1'b0;
    cyc();
    // No-write op with set_cc: nothing changes.
    wb_valid = 1'b1; wb_src_sel = 2'b11; wb_dest = 3'd4; wb_set_cc = 1'b1; alu_result = 16'h0000;
    cyc();
    go_idle();
    cyc();

    // Load timeout: 15 wait cycles, then idle with sticky flag.
    wb_valid = 1'b1; wb_src_sel = 2'b01; wb_dest = 3'd6; wb_set_cc = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      wb_valid = 1'b0; exp_rdy = 1'b0;
    end
    cyc();
    go_idle();
    exp_to = 1'b1;
    cyc();
    // PC+1 link into R7; timeout flag remains.
    reg_op(2'b10, 3'd7, 16'h3001, 1'b0, exp_cc);
    reg_op(2'b10, 3'd0, 16'hfffe, 1'b1, nzp(16'hfffe));

    // Reset during COMMIT: pending NZP update dropped.
    reg_op(2'b00, 3'd4, 16'h0005, 1'b1, 3'b001);
    wb_valid = 1'b1; wb_src_sel = 2'b00; wb_dest = 3'd6; wb_set_cc = 1'b1; alu_result = 16'h8000;
    cyc();
    wb_valid = 1'b0; reset = 1'b1;
    exp_we = 1'b1; exp_reg = 3'd6; exp_data = 16'h8000; exp_rdy = 1'b0;
    cyc();
    reset = 1'b0;
    exp_we = 1'b0; exp_wchk = 1'b1; exp_reg = 3'd0; exp_data = 16'd0;
    exp_cc = 3'b010; exp_rdy = 1'b1; exp_to = 1'b0;
    cyc();
    exp_wchk = 1'b0;
    cyc(); cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
